// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Read and write hits take zero cycles; misses stall through a line writeback and/or refill.
module dcache_controller #(
   parameter int LINES     = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_wdata_i,
   output logic [31:0]          cpu_rdata_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_wdata_o,
   input  logic [LINE_BITS-1:0] mem_rdata_i,
   input  logic                 mem_ack_i
);
   localparam int OFF_W  = $clog2(LINE_BITS / 8);
   localparam int WOFF_W = OFF_W - 2;
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int BIT_W  = $clog2(LINE_BITS);

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL_DONE} state_t;
   typedef struct packed {
      logic [TAG_W-1:0]     tag;
      logic [LINE_BITS-1:0] data;
   } line_t;

   state_t           state, state_nxt;
   line_t            lines [LINES];
   logic [LINES-1:0] valid, dirty;

   logic [WOFF_W-1:0] off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  req_tag;
   logic [BIT_W-1:0]  bit_base;
   line_t             cur;
   logic              hit;
   logic              unused_ok;

   assign off       = cpu_addr_i[OFF_W-1:2];
   assign idx       = cpu_addr_i[OFF_W +: IDX_W];
   assign req_tag   = cpu_addr_i[31 -: TAG_W];
   assign bit_base  = {off, 5'd0};
   assign cur       = lines[idx];
   assign unused_ok = ^cpu_addr_i[1:0];

   assign hit = ~rst_i & cpu_req_i & (state == IDLE) & valid[idx] & (cur.tag == req_tag);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (cpu_req_i && !hit)
                         state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
         WRITEBACK:   if (mem_ack_i) state_nxt = ALLOCATE;
         ALLOCATE:    if (mem_ack_i) state_nxt = REFILL_DONE;
         REFILL_DONE: state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Line status lives apart from the storage arrays so reset only touches these bits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         dirty <= '0;
      end else if (state == ALLOCATE && mem_ack_i) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (hit && cpu_we_i) begin
         dirty[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == ALLOCATE && mem_ack_i)
         lines[idx] <= {req_tag, mem_rdata_i};
      else if (hit && cpu_we_i)
         lines[idx].data[bit_base +: 32] <= cpu_wdata_i;
   end

   always_comb begin
      cpu_stall_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      cpu_rdata_o = hit ? cur.data[bit_base +: 32] : 32'h0;
      case (state)
         IDLE: cpu_stall_o = cpu_req_i & ~hit & ~rst_i;
         WRITEBACK: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {cur.tag, idx, {OFF_W{1'b0}}};
            mem_wdata_o = cur.data;
         end
         ALLOCATE: begin
            cpu_stall_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_addr_o  = {req_tag, idx, {OFF_W{1'b0}}};
         end
         default: cpu_stall_o = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: cold miss, hits, writeback conflict, store miss,
// reset mid-refill and stray memory acks. Memory acks every transaction on its third cycle.
module tb_dcache_controller;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall, mem_req, mem_we, mem_ack = 1'b0;
   logic [31:0]  mem_addr;
   logic [255:0] mem_wdata, mem_rdata = '0;

   int vectors = 0;
   int errs    = 0;

   int           res_stalls;
   logic [31:0]  res_rdata, res_wb_addr, res_fetch_addr;
   logic [255:0] res_wb_line;
   logic         res_wb, res_fetch, res_timeout;

   localparam logic [31:0] A_BASE = 32'hA000_0000;
   localparam logic [31:0] B_BASE = 32'hB000_0000;
   localparam logic [31:0] C_BASE = 32'hC000_0000;

   dcache_controller #(.LINES(32), .LINE_BITS(256)) dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] mk_line(input logic [31:0] base, input int w, input logic [31:0] val);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
      l[32*w +: 32] = val;
      return l;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; holds the request until the cache stops stalling,
   // lets the hit cycle's rising edge commit, then drops the request.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [255:0] fill);
      int k = 0;
      res_stalls = 0; res_wb = 0; res_fetch = 0; res_timeout = 1;
      res_rdata = '0; res_wb_addr = '0; res_fetch_addr = '0; res_wb_line = '0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      #1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (!cpu_stall) begin
            res_rdata = cpu_rdata;
            res_timeout = 0;
            break;
         end
         res_stalls++;
         if (mem_req) begin
            k++;
            if (mem_we) begin
               res_wb = 1; res_wb_addr = mem_addr; res_wb_line = mem_wdata;
            end else begin
               res_fetch = 1; res_fetch_addr = mem_addr;
            end
            if (k == 3) begin
               mem_ack = 1'b1; mem_rdata = fill; k = 0;
            end
         end
         @(negedge clk); mem_ack = 1'b0; #1;
      end
      @(negedge clk);
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   initial begin
      // reset held with a request pending: outputs must stay quiet
      cpu_req = 1'b1; cpu_addr = 32'h0000_0404;
      #1 rst = 1'b1;
      #2;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0; cpu_req = 1'b0;
      @(negedge clk);

      // cold load
      access(0, 32'h0000_0404, '0, mk_line(A_BASE, 1, 32'h1234_5678));
      chk("cold_timeout", res_timeout, 0);
      chk("cold_stalls", res_stalls, 5);
      chk("cold_no_wb", res_wb, 0);
      chk("cold_fetch_addr", res_fetch_addr, 32'h0000_0400);
      chk("cold_rdata", res_rdata, 32'h1234_5678);

      // read hits
      access(0, 32'h0000_0404, '0, '0);
      chk("hit_stalls", res_stalls, 0);
      chk("hit_no_mem", res_wb | res_fetch, 0);
      chk("hit_rdata", res_rdata, 32'h1234_5678);
      access(0, 32'h0000_0408, '0, '0);
      chk("hit_w2_rdata", res_rdata, A_BASE + 32'd2);

      // store hit, then conflicting load forces writeback
      access(1, 32'h0000_0404, 32'hDEAD_BEEF, '0);
      chk("st_hit_stalls", res_stalls, 0);
      chk("st_hit_no_mem", res_wb | res_fetch, 0);
      access(0, 32'h0000_0804, '0, mk_line(B_BASE, 1, 32'h55AA_0001));
      chk("conf_stalls", res_stalls, 8);
      chk("conf_wb", res_wb, 1);
      chk("conf_wb_addr", res_wb_addr, 32'h0000_0400);
      chk("conf_wb_line", res_wb_line, mk_line(A_BASE, 1, 32'hDEAD_BEEF));
      chk("conf_fetch_addr", res_fetch_addr, 32'h0000_0800);
      chk("conf_rdata", res_rdata, 32'h55AA_0001);

      // store miss on a clean line
      access(1, 32'h0000_1008, 32'hCAFE_F00D, mk_line(C_BASE, 0, C_BASE));
      chk("stm_stalls", res_stalls, 5);
      chk("stm_no_wb", res_wb, 0);
      chk("stm_fetch_addr", res_fetch_addr, 32'h0000_1000);
      access(0, 32'h0000_1008, '0, '0);
      chk("stm_reload_stalls", res_stalls, 0);
      chk("stm_reload_rdata", res_rdata, 32'hCAFE_F00D);
      access(0, 32'h0000_0404, '0, mk_line(A_BASE, 1, 32'h1234_5678));
      chk("stm_dirty_wb", res_wb, 1);
      chk("stm_wb_addr", res_wb_addr, 32'h0000_1000);
      chk("stm_wb_line", res_wb_line, mk_line(C_BASE, 2, 32'hCAFE_F00D));
      chk("stm_evict_stalls", res_stalls, 8);

      // reset in the middle of a refill
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0C24;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (mem_req) break;
         @(negedge clk);
      end
      chk("mid_alloc_req", mem_req, 1);
      chk("mid_alloc_addr", mem_addr, 32'h0000_0C20);
      @(negedge clk);
      rst = 1'b1; #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_stall", cpu_stall, 0);
      @(negedge clk);
      rst = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      access(0, 32'h0000_0404, '0, mk_line(A_BASE, 1, 32'h1234_5678));
      chk("post_rst_miss", res_fetch, 1);
      chk("post_rst_stalls", res_stalls, 5);
      chk("post_rst_rdata", res_rdata, 32'h1234_5678);

      // stray ack while idle must not disturb the dirty line
      access(1, 32'h0000_0404, 32'h0BAD_F00D, '0);
      mem_ack = 1'b1; mem_rdata = '1; #1;
      chk("stray_mem_req", mem_req, 0);
      chk("stray_stall", cpu_stall, 0);
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      access(0, 32'h0000_0404, '0, '0);
      chk("stray_hit_stalls", res_stalls, 0);
      chk("stray_hit_rdata", res_rdata, 32'h0BAD_F00D);
      access(0, 32'h0000_0804, '0, mk_line(B_BASE, 1, 32'h55AA_0001));
      chk("stray_dirty_wb", res_wb, 1);
      chk("stray_wb_line", res_wb_line, mk_line(A_BASE, 1, 32'h0BAD_F00D));
      chk("stray_stalls", res_stalls, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
